// File: rtl/minisys_rst_seq_pkg.sv
// Shared definitions for the MiniSys clock/reset sequencer.
//   RstEnable / RstDisable : reset polarity (active-high)
//   rsq_state_e            : 2-bit sequencer state encoding
//   rsq_cnt_width()        : width of the release counter
package minisys_rst_seq_pkg;

   localparam logic RstEnable  = 1'b1;
   localparam logic RstDisable = 1'b0;

   typedef enum logic [1:0] {
      StReset   = 2'b00,
      StHold    = 2'b01,
      StStagger = 2'b10,
      StRun     = 2'b11
   } rsq_state_e;

   function automatic int unsigned rsq_cnt_width(input int unsigned hold,
                                                 input int unsigned n,
                                                 input int unsigned stagger);
      return $clog2(hold + n * stagger + 1);
   endfunction

endpackage

// File: rtl/minisys_rst_seq_if.sv
// Control/status bundle between the reset sequencer and the rest of the system.
//   soft_rst_req : synchronous soft-reset request (level)
//   wdt_kick     : watchdog kick (level)
//   rst_out      : per-domain reset, active-high, bit 0 released first
//   ready        : all domains out of reset
//   clk_en       : slow-peripheral clock enable pulse
//   wdt_fired    : sticky watchdog-reset flag
// Modports: master = sequencer, slave = system side.
interface minisys_rst_seq_if #(
   parameter int unsigned N_DOMAINS = 3
) ();

   logic                 soft_rst_req;
   logic                 wdt_kick;
   logic [N_DOMAINS-1:0] rst_out;
   logic                 ready;
   logic                 clk_en;
   logic                 wdt_fired;

   modport master (
      input  soft_rst_req,
      input  wdt_kick,
      output rst_out,
      output ready,
      output clk_en,
      output wdt_fired
   );

   modport slave (
      output soft_rst_req,
      output wdt_kick,
      input  rst_out,
      input  ready,
      input  clk_en,
      input  wdt_fired
   );

endinterface

// File: rtl/minisys_rst_seq_reset_sync.sv
// Two-flop reset synchronizer: asynchronous assertion, deassertion on the second
// rising clock edge after rst falls.
//   clk      : destination clock
//   rst      : asynchronous reset, active-high
//   rst_sync : synchronized reset, active-high
module minisys_rst_seq_reset_sync
   import minisys_rst_seq_pkg::*;
(
   input  logic clk,
   input  logic rst,
   output logic rst_sync
);

   logic [1:0] sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst == RstEnable) begin
         sync_q <= {2{RstEnable}};
      end else begin
         sync_q <= {sync_q[0], RstDisable};
      end
   end

   assign rst_sync = sync_q[1];

endmodule

// File: rtl/minisys_rst_seq.sv
// MiniSys clock/reset sequencer. Releases N_DOMAINS reset outputs one by one
// after a hold period, then runs a clk_en divider. Soft reset (and, with
// NCUT_WATCHDOG_EN defined, a watchdog timeout) restarts the hold sequence.
//   clk : system clock
//   rst : asynchronous reset, active-high
//   bus : minisys_rst_seq_if master (soft_rst_req, wdt_kick in;
//         rst_out, ready, clk_en, wdt_fired out)
// Optional build macro: NCUT_WATCHDOG_EN (watchdog; otherwise wdt_fired = 0).
module minisys_rst_seq
   import minisys_rst_seq_pkg::*;
#(
   parameter int unsigned N_DOMAINS   = 3,
   parameter int unsigned HOLD_CYCLES = 16,
   parameter int unsigned STAGGER     = 4,
   parameter int unsigned CE_DIV      = 2,
   parameter int unsigned WDT_CYCLES  = 1024
) (
   input logic               clk,
   input logic               rst,
   minisys_rst_seq_if.master bus
);

   localparam int unsigned CntW     = rsq_cnt_width(HOLD_CYCLES, N_DOMAINS, STAGGER);
   localparam int unsigned RunCount = HOLD_CYCLES + (N_DOMAINS - 1) * STAGGER;
   localparam int unsigned DivW     = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
   localparam logic [DivW-1:0] DivLast = DivW'(CE_DIV - 1);

   logic                 rst_sync;
   rsq_state_e           state, state_q, state_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic [DivW-1:0]      div_q, div_d;
   logic [N_DOMAINS-1:0] rst_out_q, rst_out_d;
   logic                 ready_q, ready_d;
   logic                 clk_en_q, clk_en_d;
   logic                 restart;
   logic                 wdt_timeout;

   minisys_rst_seq_reset_sync u_reset_sync (
      .clk      (clk),
      .rst      (rst),
      .rst_sync (rst_sync)
   );

   // RESET is defined by the synchronizer output, so HOLD (count 0) begins on
   // the same edge that the synchronizer releases.
   assign state   = (rst_sync == RstEnable) ? StReset : state_q;
   assign restart = (state != StReset) && (bus.soft_rst_req || wdt_timeout);

   always_comb begin
      cnt_d    = cnt_q;
      div_d    = '0;
      clk_en_d = 1'b0;

      unique case (state)
         StReset:   cnt_d = '0;
         StHold:    cnt_d = cnt_q + 1'b1;
         StStagger: cnt_d = cnt_q + 1'b1;
         StRun:     cnt_d = cnt_q;  // saturated
      endcase
      if (restart) begin
         cnt_d = '0;
      end

      // State and every output are a pure function of the elapsed count, which
      // guarantees in-order, edge-aligned release.
      if (32'(cnt_d) >= RunCount) begin
         state_d = StRun;
      end else if (32'(cnt_d) >= HOLD_CYCLES) begin
         state_d = StStagger;
      end else begin
         state_d = StHold;
      end
      for (int unsigned i = 0; i < N_DOMAINS; i++) begin
         rst_out_d[i] = (32'(cnt_d) >= HOLD_CYCLES + i * STAGGER) ? RstDisable : RstEnable;
      end
      ready_d = (state_d == StRun);

      if ((state == StRun) && !restart) begin
         if (div_q == DivLast) begin
            clk_en_d = 1'b1;
         end else begin
            div_d = div_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst == RstEnable) begin
         state_q   <= StReset;
         cnt_q     <= '0;
         div_q     <= '0;
         rst_out_q <= {N_DOMAINS{RstEnable}};
         ready_q   <= 1'b0;
         clk_en_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         div_q     <= div_d;
         rst_out_q <= rst_out_d;
         ready_q   <= ready_d;
         clk_en_q  <= clk_en_d;
      end
   end

   assign bus.rst_out = rst_out_q;
   assign bus.ready   = ready_q;
   assign bus.clk_en  = clk_en_q;

`ifdef NCUT_WATCHDOG_EN
   localparam int unsigned WdtW = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;

   logic [WdtW-1:0] wdt_q, wdt_d;
   logic            wdt_fired_q;

   // Timeout fires on the edge where the count would reach WDT_CYCLES-1; a kick wins.
   assign wdt_timeout = (state == StRun) && !bus.wdt_kick &&
                        (32'(wdt_q) + 32'd1 == WDT_CYCLES - 1);

   always_comb begin
      wdt_d = '0;
      if ((state == StRun) && !bus.wdt_kick && !restart) begin
         wdt_d = wdt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst == RstEnable) begin
         wdt_q       <= '0;
         wdt_fired_q <= 1'b0;
      end else begin
         wdt_q       <= wdt_d;
         wdt_fired_q <= wdt_fired_q | wdt_timeout;
      end
   end

   assign bus.wdt_fired = wdt_fired_q;
`else
   logic unused_wdt;
   assign unused_wdt    = bus.wdt_kick ^ (WDT_CYCLES == 0);
   assign wdt_timeout   = 1'b0;
   assign bus.wdt_fired = 1'b0;
`endif

endmodule
